// File: rtl/vvm_phase_avg.sv
// Averages per-channel phase relative to channel 0 over 2^avg_shift frames, with wrap-safe accumulation.
// Latency: the first burst word appears 2 cycles after the phs(N_CH-1) word of the closing frame; the burst lasts N_CH-1 cycles.
// No backpressure: the stream is accepted on every strobe, and a truncated frame is dropped and flagged on frame_err.
module vvm_phase_avg #(
  parameter int DW        = 21,
  parameter int N_CH      = 4,
  parameter int MAX_SHIFT = 15
) (
  input  logic          sample_clk,
  input  logic          sample_rst_n,
  input  logic [DW-1:0] stream_in,
  input  logic          strobe_in,
  input  logic [3:0]    avg_shift,
  output logic [DW-1:0] diff_out,
  output logic [2:0]    ch_out,
  output logic          strobe_out,
  output logic          frame_err
);

  localparam int NW  = 2 * N_CH;
  localparam int WW  = $clog2(NW);
  localparam int NM  = N_CH - 1;
  localparam int DBN = (NM > 1) ? NM - 1 : 1;
  localparam int AW  = DW + MAX_SHIFT + 1;
  localparam int FCW = MAX_SHIFT;
  localparam logic [WW-1:0] W_LAST = WW'(NW - 1);

  // Frame capture: word index, reference phase, and differences held until the frame completes
  logic [WW-1:0]        w;
  logic [DW-1:0]        p0;
  logic [DW-1:0]        dbuf [DBN];

  // Window state: per-channel anchor and the accumulated offsets from that anchor
  logic [DW-1:0]        ref_q [NM];
  logic signed [AW-1:0] acc_q [NM];
  logic [FCW-1:0]       fc;
  logic [3:0]           s_win;
  logic [3:0]           close_s;
  logic                 close_p;

  // Combinational helpers
  logic [3:0]           s_clamp;
  logic [3:0]           s_eff;
  logic [FCW-1:0]       fc_last;
  logic                 first_frame;
  logic                 frame_end;
  logic [DW-1:0]        d_now;
  logic [DW-1:0]        step;
  logic [DW-1:0]        d_frame [NM];
  logic signed [AW-1:0] acc_nxt [NM];
  logic [DW-1:0]        res     [NM];

  // Output burst buffer, kept apart from the accumulators so that the next window can run during a burst
  logic [DW-1:0]        obuf [NM];
  logic [2:0]           bidx;

  // Differences, accumulator updates and window results derived from the current state
  always_comb begin
    s_clamp     = (avg_shift > 4'(MAX_SHIFT)) ? 4'(MAX_SHIFT) : avg_shift;
    first_frame = (fc == '0);
    // The shift is captured on the first frame of a window, so that frame must use the live input
    s_eff       = first_frame ? s_clamp : s_win;
    fc_last     = FCW'((32'd1 << s_eff) - 32'd1);
    frame_end   = strobe_in && (w == W_LAST);
    d_now       = stream_in - p0;
    step        = '0;
    for (int k = 0; k < NM; k++) begin
      d_frame[k] = (k == NM - 1) ? d_now : dbuf[(k < DBN) ? k : 0];
      // Each step from the anchor is wrapped to +/-pi before it is summed; this makes the average unwrap-safe
      step       = d_frame[k] - ref_q[k];
      acc_nxt[k] = acc_q[k] + AW'(signed'(step));
      res[k]     = ref_q[k] + DW'(acc_q[k] >>> close_s);
    end
  end

  // Frame parsing, truncation detection and window accumulation
  always_ff @(posedge sample_clk or negedge sample_rst_n) begin
    if (!sample_rst_n) begin
      w         <= '0;
      p0        <= '0;
      fc        <= '0;
      s_win     <= '0;
      close_s   <= '0;
      close_p   <= 1'b0;
      frame_err <= 1'b0;
      for (int k = 0; k < DBN; k++) dbuf[k] <= '0;
      for (int k = 0; k < NM; k++) begin
        ref_q[k] <= '0;
        acc_q[k] <= '0;
      end
    end else begin
      frame_err <= 1'b0;
      close_p   <= 1'b0;
      if (strobe_in) begin
        w <= (w == W_LAST) ? '0 : w + WW'(1);
        if (w == WW'(1)) p0 <= stream_in;
        // Hold intermediate differences so that a truncated frame never touches the accumulators
        for (int k = 0; k < NM - 1; k++) begin
          if (w == WW'(2 * k + 3)) dbuf[k] <= d_now;
        end
        if (frame_end) begin
          for (int k = 0; k < NM; k++) begin
            if (first_frame) begin
              ref_q[k] <= d_frame[k];
              acc_q[k] <= '0;
            end else begin
              acc_q[k] <= acc_nxt[k];
            end
          end
          if (first_frame) s_win <= s_clamp;
          if (fc == fc_last) begin
            fc      <= '0;
            close_p <= 1'b1;
            close_s <= s_eff;
          end else begin
            fc <= fc + FCW'(1);
          end
        end
      end else if (w != '0) begin
        w         <= '0;
        frame_err <= 1'b1;
      end
    end
  end

  // Latch window results into the output buffer and stream them out one channel per cycle
  always_ff @(posedge sample_clk or negedge sample_rst_n) begin
    if (!sample_rst_n) begin
      strobe_out <= 1'b0;
      diff_out   <= '0;
      ch_out     <= '0;
      bidx       <= '0;
      for (int k = 0; k < NM; k++) obuf[k] <= '0;
    end else if (close_p) begin
      for (int k = 0; k < NM; k++) obuf[k] <= res[k];
      diff_out   <= res[0];
      ch_out     <= 3'd1;
      strobe_out <= 1'b1;
      bidx       <= 3'd1;
    end else if (strobe_out && (bidx != 3'(NM))) begin
      for (int k = 0; k < NM; k++) begin
        if (bidx == 3'(k)) diff_out <= obuf[k];
      end
      ch_out <= bidx + 3'd1;
      bidx   <= bidx + 3'd1;
    end else begin
      strobe_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vvm_phase_avg.sv
// Directed bench for vvm_phase_avg: frames are driven word by word, and expected burst words are queued per frame.
// Latency: each queued word carries the exact cycle at which it must appear.
// No backpressure: the monitor pops one expectation for each strobe_out cycle.
module tb_vvm_phase_avg;

  logic        sample_clk;
  logic        sample_rst_n;
  logic [20:0] stream_in;
  logic        strobe_in;
  logic [3:0]  avg_shift;
  logic [20:0] diff_out;
  logic [2:0]  ch_out;
  logic        strobe_out;
  logic        frame_err;

  typedef struct {
    int ch;
    int val;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  int   n_err    = 0;
  int   err_cyc  = -1;

  vvm_phase_avg #(.DW(21), .N_CH(4), .MAX_SHIFT(15)) dut (
    .sample_clk   (sample_clk),
    .sample_rst_n (sample_rst_n),
    .stream_in    (stream_in),
    .strobe_in    (strobe_in),
    .avg_shift    (avg_shift),
    .diff_out     (diff_out),
    .ch_out       (ch_out),
    .strobe_out   (strobe_out),
    .frame_err    (frame_err)
  );

  initial begin
    sample_clk = 1'b0;
    forever #5 sample_clk = ~sample_clk;
  end

  initial forever begin
    @(posedge sample_clk);
    cyc++;
  end

  function automatic logic [31:0] sx(input logic [20:0] v);
    return {{11{v[20]}}, v};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp_v));
    end
  endtask

  // Monitor: count frame_err pulses and compare every burst word against the scoreboard
  initial forever begin
    @(negedge sample_clk);
    if (frame_err === 1'b1) begin
      n_err++;
      err_cyc = cyc;
    end
    if (strobe_out === 1'b1) begin
      if (sbq.size() == 0) begin
        check("unexpected_strobe_out", 32'(strobe_out), 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("burst_ch", 32'(ch_out), 32'(e.ch));
        check("burst_diff", sx(diff_out), 32'(e.val));
        check("burst_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic drive(input int v, input bit s);
    @(posedge sample_clk);
    #1;
    stream_in = 21'(v);
    strobe_in = s;
  endtask

  task automatic frame(input int p0, input int p1, input int p2, input int p3,
                       input bit burst, input int e1, input int e2, input int e3);
    int ph[4];
    int c;
    ph = '{p0, p1, p2, p3};
    for (int k = 0; k < 4; k++) begin
      drive(12345 + k, 1'b1);
      drive(ph[k], 1'b1);
    end
    c = cyc;
    if (burst) begin
      sbq.push_back('{ch: 1, val: e1, cyc: c + 2});
      sbq.push_back('{ch: 2, val: e2, cyc: c + 3});
      sbq.push_back('{ch: 3, val: e3, cyc: c + 4});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 1'b0);
  endtask

  initial begin
    int  drop_cyc;
    bit  found;
    sample_rst_n = 1'b0;
    stream_in    = '0;
    strobe_in    = 1'b0;
    avg_shift    = 4'd0;
    #12;
    check("rst_strobe_out", 32'(strobe_out), 32'd0);
    check("rst_diff_out", 32'(diff_out), 32'd0);
    check("rst_ch_out", 32'(ch_out), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    @(negedge sample_clk);
    #2 sample_rst_n = 1'b1;

    // Constant phase, S=0, three back-to-back frames
    for (int f = 0; f < 3; f++)
      frame(0, 349525, -349525, 1000, 1'b1, 349525, -349525, 1000);
    idle(6);

    // Wrap of the difference across +/-pi
    frame(-1048000, 1048000, 0, 0, 1'b1, -1152, 1048000, 1048000);
    idle(6);

    // S=1 average across +/-pi
    avg_shift = 4'd1;
    frame(0, 1048570, 0, 0, 1'b0, 0, 0, 0);
    frame(0, -1048570, 0, 0, 1'b1, -1048576, 0, 0);
    idle(6);

    // S=4, 16 back-to-back frames; the results exercise floor rounding
    avg_shift = 4'd4;
    for (int i = 0; i < 16; i++)
      frame(1000 * i, 1000 * i + 100 + i, 1000 * i + 20000 - (i % 2), 1000 * i - 7,
            i == 15, 107, 19999, -7);
    idle(6);
    check("no_frame_err_yet", 32'(n_err), 32'd0);

    // Truncated frame, then two full frames with S=1
    avg_shift = 4'd1;
    drive(11, 1'b1);
    drive(22, 1'b1);
    drive(33, 1'b1);
    drive(0, 1'b0);
    drop_cyc = cyc;
    idle(3);
    check("frame_err_cycle", 32'(err_cyc), 32'(drop_cyc + 1));
    frame(0, 500, 600, 700, 1'b0, 0, 0, 0);
    frame(0, 502, 600, -700, 1'b1, 501, 600, 0);
    idle(6);

    // Async reset in the middle of a burst
    avg_shift = 4'd0;
    frame(0, 111, 222, 333, 1'b1, 111, 222, 333);
    drive(0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge sample_clk);
      if (strobe_out === 1'b1) found = 1'b1;
    end
    check("midburst_seen", 32'(found), 32'd1);
    #2 sample_rst_n = 1'b0;
    #1;
    sbq.delete();
    check("midburst_rst_strobe", 32'(strobe_out), 32'd0);
    check("midburst_rst_diff", 32'(diff_out), 32'd0);
    check("midburst_rst_ch", 32'(ch_out), 32'd0);
    check("midburst_rst_err", 32'(frame_err), 32'd0);
    @(negedge sample_clk);
    @(negedge sample_clk);
    #2 sample_rst_n = 1'b1;
    idle(4);

    // Async reset mid-window and mid-frame with S=2; after release, a full 4-frame window is needed
    avg_shift = 4'd2;
    frame(0, 5000, 5000, 5000, 1'b0, 0, 0, 0);
    frame(0, 5000, 5000, 5000, 1'b0, 0, 0, 0);
    drive(7, 1'b1);
    drive(0, 1'b1);
    drive(7, 1'b1);
    #3;
    sample_rst_n = 1'b0;
    strobe_in    = 1'b0;
    #1;
    check("midwin_rst_strobe", 32'(strobe_out), 32'd0);
    check("midwin_rst_err", 32'(frame_err), 32'd0);
    @(negedge sample_clk);
    @(negedge sample_clk);
    #2 sample_rst_n = 1'b1;
    for (int f = 0; f < 4; f++)
      frame(10, 20, 30, 40, f == 3, 10, 20, 30);
    idle(8);

    check("scoreboard_empty", 32'(sbq.size()), 32'd0);
    check("frame_err_count", 32'(n_err), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vvm_phase_avg.md
Name: vvm_phase_avg

Overview:
- Sits directly downstream of vvm_dsp.
- Consumes vvm_dsp's time-multiplexed magnitude/phase result stream (result_iq / result_strobe).
- Computes the phase of each measurement channel relative to the reference channel 0, then averages it over 2^avg_shift frames with wrap-safe (unwrapped) accumulation.
- Emits the averaged phase differences as a short serial burst for the register bank / readout.

Parameters:
DW, 21, word width of stream_in and diff_out; phase full scale 2^DW = 2*pi, two's complement
N_CH, 4, channels per frame (channel 0 = reference), 2..8
MAX_SHIFT, 15, largest supported avg_shift; accumulator width DW+MAX_SHIFT+1

Ports:
sample_clk  in  1  ADC sample clock
sample_rst_n  in  1  asynchronous, active-low reset
stream_in  in  DW  serial words: mag0, phs0, mag1, phs1, ... mag(N_CH-1), phs(N_CH-1)
strobe_in  in  1  high for each valid stream_in word; a frame is 2*N_CH consecutive strobed cycles
avg_shift  in  4  log2 of frames per averaging window; values above MAX_SHIFT clamp to MAX_SHIFT
diff_out  out  DW  averaged phase difference, signed, wrapped to DW bits
ch_out  out  3  channel index k (1..N_CH-1) of the current diff_out word
strobe_out  out  1  high for N_CH-1 consecutive cycles per completed window
frame_err  out  1  one-cycle pulse when a frame is truncated

Behaviour:
- Reset: all outputs 0; word index, frame count, accumulators, ref registers and output buffer cleared.
- Reset acts asynchronously at any time, including mid-frame or mid-burst. Any burst in progress is dropped with no partial output.
- Word index w counts strobed cycles 0..2*N_CH-1.
  - Odd w carries phase; even w carries magnitude and is ignored.
  - At w = 2*N_CH-1 the index wraps to 0, so back-to-back frames need no gap.
- Truncated frame: strobe_in low while w != 0.
  - frame_err pulses the next cycle and w returns to 0.
  - The partial frame is discarded and does not count toward the window.
- Phase differences: p0 latched at w=1. For each k >= 1, d_k = (phs_k - p0) mod 2^DW, signed.
- Window state, per channel k:
  - Registers: ref_k (DW) and acc_k (DW+MAX_SHIFT+1, signed).
  - Frame counter fc counts 0..2^S-1.
  - S = avg_shift, sampled at the first frame of each window. A mid-window change takes effect in the next window.
- First frame of a window (fc=0): ref_k <= d_k, acc_k <= 0.
- Subsequent frames: acc_k <= acc_k + sext(wrap_DW(d_k - ref_k)).
- On the last frame (fc = 2^S-1), after channel N_CH-1 is processed:
  - result_k = wrap_DW(ref_k + (acc_k >>> S)), arithmetic shift, truncating toward -inf.
  - The results are latched into the output buffer, and fc returns to 0.
- S=0: every frame closes a window and result_k = d_k.
- Output burst:
  - strobe_out rises 2 cycles after the strobed cycle carrying phs(N_CH-1) of the closing frame.
  - It stays high N_CH-1 cycles; ch_out = 1, 2, ... N_CH-1, with diff_out = result_k.
  - diff_out and ch_out hold their last values when strobe_out is low.
- The output buffer is separate from the accumulators. A burst overlapping the next frame's input is not corrupted, and the next window accumulates normally during it.
- Windows are never shorter than the minimum frame spacing (2*N_CH cycles > N_CH-1), so bursts never collide.
- Accumulator headroom: at most 2^15 terms of |x| <= 2^(DW-1), so no overflow is possible.

Test Plan:
- Constant phase, S=0, DW=21, N_CH=4: phs0=0, phs1=349525, phs2=-349525, phs3=1000 each frame -> every frame a burst (1,349525),(2,-349525),(3,1000), strobe_out rising 2 cycles after the phs3 word.
- Wrap of difference, S=0: phs0=-1048000, phs1=1048000 -> diff_out for ch 1 = -1152.
- Averaging across +/-pi, S=1: phs0=0, phs1 alternating 1048570 / -1048570 -> ch 1 result = -1048576. A naive average would give 0, which is wrong.
- Averaging, S=4, 16 back-to-back frames (no gaps) with phs1-phs0 stepping 100..115 -> exactly one burst, ch 1 = 107 (floor of mean 107.5). frame_err stays 0 throughout.
- Truncated frame: strobe_in drops after 3 words, then full frames with S=1 -> frame_err pulses once. The next burst appears only after 2 complete frames.
- Async reset asserted mid-burst and mid-window -> all outputs 0 immediately, remaining burst words suppressed. After release, the first burst comes 2^S full frames later.
